// File: rtl/proctypes.sv
// rtl/proctypes.sv - shared rend3r instruction, shape and sequencer types
package proctypes;

    localparam int LIGHT_IDX_W  = 6;
    localparam int SHAPE_IDX_W  = 19;
    localparam int PROP_W       = 5;
    localparam int DATA_W       = 16;
    localparam int NUM_LIGHTS_W = LIGHT_IDX_W + 1;
    localparam int NUM_SHAPES_W = SHAPE_IDX_W + 1;

    // Shape property slot that holds the shape's type rather than a parameter.
    localparam logic [PROP_W-1:0] SHAPE_TYPE_PROP = 5'd31;

    typedef enum logic [2:0] {
        opUnsupported = 3'd0,
        opCameraSet   = 3'd1,
        opLightSet    = 3'd2,
        opShapeInit   = 3'd3,
        opShapeSet    = 3'd4,
        opShapeData   = 3'd5,
        opRender      = 3'd6,
        opFrame       = 3'd7
    } InstType;

    typedef enum logic [4:0] {
        stOff      = 5'd0,
        stPlane    = 5'd1,
        stBox      = 5'd2,
        stCylinder = 5'd3,
        stCone     = 5'd4,
        stSphere   = 5'd5
    } ShapeType;

    typedef enum logic [4:0] {
        cpPosX   = 5'd0,
        cpPosY   = 5'd1,
        cpPosZ   = 5'd2,
        cpFovHor = 5'd12,
        cpFovVer = 5'd13
    } CameraProperty;

    typedef logic [LIGHT_IDX_W-1:0] LightIndex;
    typedef logic [SHAPE_IDX_W-1:0] ShapeIndex;

    // 75-bit decoded instruction: 3+5+6+19+5+16+5+16.
    typedef struct packed {
        InstType             iType;
        ShapeType            sType;
        LightIndex           lIndex;
        ShapeIndex           sIndex;
        logic [PROP_W-1:0]   prop;
        logic [DATA_W-1:0]   data;
        logic [PROP_W-1:0]   prop2;
        logic [DATA_W-1:0]   data2;
    } DecodedInst;

    typedef enum logic [1:0] {
        SEQ_IDLE        = 2'd0,
        SEQ_WR2         = 2'd1,
        SEQ_RENDER_WAIT = 2'd2,
        SEQ_FRAME_WAIT  = 2'd3
    } SeqState;

    // Instructions that modify scene tables and so must not overlap a render.
    function automatic logic is_scene_write(input InstType t);
        return (t == opCameraSet) || (t == opLightSet) || (t == opShapeInit) ||
               (t == opShapeSet)  || (t == opShapeData);
    endfunction

endpackage

// File: rtl/scene_cmd_sequencer.sv
// rtl/scene_cmd_sequencer.sv - turns decoded rend3r instructions into scene table writes and render/frame commands
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   inst_valid/inst/inst_ready decoded instruction handshake
//   render_busy                render core is reading scene tables (blocks writes)
//   render_done, frame_done    one-cycle acknowledgements of render_start / frame_swap
//   cam_*                      camera register file write port
//   light_*                    light table write port
//   shape_*                    shape table write port (prop 31 = type slot)
//   render_start, frame_swap   one-cycle command pulses
//   num_lights, num_shapes     highest written index + 1
//   err_count                  saturating count of unsupported instructions
module scene_cmd_sequencer
    import proctypes::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_valid,
    input  DecodedInst              inst,
    output logic                    inst_ready,
    input  logic                    render_busy,
    input  logic                    render_done,
    input  logic                    frame_done,
    output logic                    cam_we,
    output logic [PROP_W-1:0]       cam_prop,
    output logic [DATA_W-1:0]       cam_data,
    output logic                    light_we,
    output logic [LIGHT_IDX_W-1:0]  light_idx,
    output logic [PROP_W-1:0]       light_prop,
    output logic [DATA_W-1:0]       light_data,
    output logic                    shape_we,
    output logic [SHAPE_IDX_W-1:0]  shape_idx,
    output logic [PROP_W-1:0]       shape_prop,
    output logic [DATA_W-1:0]       shape_data,
    output logic                    render_start,
    output logic                    frame_swap,
    output logic [NUM_LIGHTS_W-1:0] num_lights,
    output logic [NUM_SHAPES_W-1:0] num_shapes,
    output logic [ERR_CNT_W-1:0]    err_count
);

    SeqState r_state, w_state_next;

    logic                    r_cam_we, w_cam_we;
    logic [PROP_W-1:0]       r_cam_prop, w_cam_prop;
    logic [DATA_W-1:0]       r_cam_data, w_cam_data;
    logic                    r_light_we, w_light_we;
    logic [LIGHT_IDX_W-1:0]  r_light_idx, w_light_idx;
    logic [PROP_W-1:0]       r_light_prop, w_light_prop;
    logic [DATA_W-1:0]       r_light_data, w_light_data;
    logic                    r_shape_we, w_shape_we;
    logic [SHAPE_IDX_W-1:0]  r_shape_idx, w_shape_idx;
    logic [PROP_W-1:0]       r_shape_prop, w_shape_prop;
    logic [DATA_W-1:0]       r_shape_data, w_shape_data;
    logic                    r_render_start, w_render_start;
    logic                    r_frame_swap, w_frame_swap;
    logic [NUM_LIGHTS_W-1:0] r_num_lights, w_num_lights;
    logic [NUM_SHAPES_W-1:0] r_num_shapes, w_num_shapes;
    logic [ERR_CNT_W-1:0]    r_err_count, w_err_count;

    // Second half of an opShapeData, replayed from WR2.
    logic [PROP_W-1:0]       r_wr2_prop, w_wr2_prop;
    logic [DATA_W-1:0]       r_wr2_data, w_wr2_data;

    logic                    w_ready;
    logic                    w_accept;
    logic [NUM_LIGHTS_W-1:0] w_light_cnt;
    logic [NUM_SHAPES_W-1:0] w_shape_cnt;

    always_comb begin
        w_ready        = (r_state == SEQ_IDLE) && !(render_busy && is_scene_write(inst.iType));
        w_accept       = inst_valid && w_ready;
        w_light_cnt    = {1'b0, inst.lIndex} + NUM_LIGHTS_W'(1);
        w_shape_cnt    = {1'b0, inst.sIndex} + NUM_SHAPES_W'(1);

        w_state_next   = r_state;
        w_cam_we       = 1'b0;
        w_cam_prop     = r_cam_prop;
        w_cam_data     = r_cam_data;
        w_light_we     = 1'b0;
        w_light_idx    = r_light_idx;
        w_light_prop   = r_light_prop;
        w_light_data   = r_light_data;
        w_shape_we     = 1'b0;
        w_shape_idx    = r_shape_idx;
        w_shape_prop   = r_shape_prop;
        w_shape_data   = r_shape_data;
        w_render_start = 1'b0;
        w_frame_swap   = 1'b0;
        w_num_lights   = r_num_lights;
        w_num_shapes   = r_num_shapes;
        w_err_count    = r_err_count;
        w_wr2_prop     = r_wr2_prop;
        w_wr2_data     = r_wr2_data;

        case (r_state)
            SEQ_IDLE: begin
                if (w_accept) begin
                    case (inst.iType)
                        opCameraSet: begin
                            w_cam_we   = 1'b1;
                            w_cam_prop = inst.prop;
                            w_cam_data = inst.data;
                        end
                        opLightSet: begin
                            w_light_we   = 1'b1;
                            w_light_idx  = inst.lIndex;
                            w_light_prop = inst.prop;
                            w_light_data = inst.data;
                            if (w_light_cnt > r_num_lights) begin
                                w_num_lights = w_light_cnt;
                            end
                        end
                        opShapeInit: begin
                            w_shape_we   = 1'b1;
                            w_shape_idx  = inst.sIndex;
                            w_shape_prop = SHAPE_TYPE_PROP;
                            w_shape_data = {11'b0, inst.sType};
                            // Switching a shape off still writes its type slot but never grows the table.
                            if ((inst.sType != stOff) && (w_shape_cnt > r_num_shapes)) begin
                                w_num_shapes = w_shape_cnt;
                            end
                        end
                        opShapeSet: begin
                            w_shape_we   = 1'b1;
                            w_shape_idx  = inst.sIndex;
                            w_shape_prop = inst.prop;
                            w_shape_data = inst.data;
                        end
                        opShapeData: begin
                            w_shape_we   = 1'b1;
                            w_shape_idx  = inst.sIndex;
                            w_shape_prop = inst.prop;
                            w_shape_data = inst.data;
                            w_wr2_prop   = inst.prop2;
                            w_wr2_data   = inst.data2;
                            w_state_next = SEQ_WR2;
                        end
                        opRender: begin
                            w_render_start = 1'b1;
                            w_state_next   = SEQ_RENDER_WAIT;
                        end
                        opFrame: begin
                            w_frame_swap = 1'b1;
                            w_state_next = SEQ_FRAME_WAIT;
                        end
                        default: begin
                            if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                                w_err_count = r_err_count + ERR_CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
            SEQ_WR2: begin
                // shape_idx still holds the sIndex from the first write.
                w_shape_we   = 1'b1;
                w_shape_prop = r_wr2_prop;
                w_shape_data = r_wr2_data;
                w_state_next = SEQ_IDLE;
            end
            SEQ_RENDER_WAIT: begin
                if (render_done) begin
                    w_state_next = SEQ_IDLE;
                end
            end
            SEQ_FRAME_WAIT: begin
                if (frame_done) begin
                    w_state_next = SEQ_IDLE;
                end
            end
            default: w_state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= SEQ_IDLE;
            r_cam_we       <= 1'b0;
            r_cam_prop     <= '0;
            r_cam_data     <= '0;
            r_light_we     <= 1'b0;
            r_light_idx    <= '0;
            r_light_prop   <= '0;
            r_light_data   <= '0;
            r_shape_we     <= 1'b0;
            r_shape_idx    <= '0;
            r_shape_prop   <= '0;
            r_shape_data   <= '0;
            r_render_start <= 1'b0;
            r_frame_swap   <= 1'b0;
            r_num_lights   <= '0;
            r_num_shapes   <= '0;
            r_err_count    <= '0;
            r_wr2_prop     <= '0;
            r_wr2_data     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cam_we       <= w_cam_we;
            r_cam_prop     <= w_cam_prop;
            r_cam_data     <= w_cam_data;
            r_light_we     <= w_light_we;
            r_light_idx    <= w_light_idx;
            r_light_prop   <= w_light_prop;
            r_light_data   <= w_light_data;
            r_shape_we     <= w_shape_we;
            r_shape_idx    <= w_shape_idx;
            r_shape_prop   <= w_shape_prop;
            r_shape_data   <= w_shape_data;
            r_render_start <= w_render_start;
            r_frame_swap   <= w_frame_swap;
            r_num_lights   <= w_num_lights;
            r_num_shapes   <= w_num_shapes;
            r_err_count    <= w_err_count;
            r_wr2_prop     <= w_wr2_prop;
            r_wr2_data     <= w_wr2_data;
        end
    end

    assign inst_ready   = w_ready;
    assign cam_we       = r_cam_we;
    assign cam_prop     = r_cam_prop;
    assign cam_data     = r_cam_data;
    assign light_we     = r_light_we;
    assign light_idx    = r_light_idx;
    assign light_prop   = r_light_prop;
    assign light_data   = r_light_data;
    assign shape_we     = r_shape_we;
    assign shape_idx    = r_shape_idx;
    assign shape_prop   = r_shape_prop;
    assign shape_data   = r_shape_data;
    assign render_start = r_render_start;
    assign frame_swap   = r_frame_swap;
    assign num_lights   = r_num_lights;
    assign num_shapes   = r_num_shapes;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_scene_cmd_sequencer.sv
// tb/tb_scene_cmd_sequencer.sv - scoreboard bench for scene_cmd_sequencer
module tb_scene_cmd_sequencer;
    import proctypes::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    DecodedInst  inst;
    logic        inst_ready;
    logic        render_busy;
    logic        render_done;
    logic        frame_done;
    logic        cam_we;
    logic [4:0]  cam_prop;
    logic [15:0] cam_data;
    logic        light_we;
    logic [5:0]  light_idx;
    logic [4:0]  light_prop;
    logic [15:0] light_data;
    logic        shape_we;
    logic [18:0] shape_idx;
    logic [4:0]  shape_prop;
    logic [15:0] shape_data;
    logic        render_start;
    logic        frame_swap;
    logic [6:0]  num_lights;
    logic [19:0] num_shapes;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    scene_cmd_sequencer #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .render_busy(render_busy), .render_done(render_done), .frame_done(frame_done),
        .cam_we(cam_we), .cam_prop(cam_prop), .cam_data(cam_data),
        .light_we(light_we), .light_idx(light_idx), .light_prop(light_prop), .light_data(light_data),
        .shape_we(shape_we), .shape_idx(shape_idx), .shape_prop(shape_prop), .shape_data(shape_data),
        .render_start(render_start), .frame_swap(frame_swap),
        .num_lights(num_lights), .num_shapes(num_shapes), .err_count(err_count)
    );

    // kind: 0 camera, 1 light, 2 shape, 3 render, 4 frame
    typedef struct {
        int          kind;
        logic [18:0] idx;
        logic [4:0]  prop;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_nl = 0;
    int   m_ns = 0;
    int   m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_pop(input int kind, input logic [18:0] idx, input logic [4:0] prop,
                           input logic [15:0] data);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got kind %0d idx %0h prop %0h data %0h expected none at %0t",
                     kind, idx, prop, data, $time);
        end else begin
            e = q.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_idx", {13'b0, idx}, {13'b0, e.idx});
            chk("strobe_prop", {27'b0, prop}, {27'b0, e.prop});
            chk("strobe_data", {16'b0, data}, {16'b0, e.data});
        end
    endtask

    // Monitor: every strobe seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        chk("single_strobe_group",
            32'(int'(cam_we) + int'(light_we) + int'(shape_we) + int'(render_start) + int'(frame_swap) <= 1),
            32'd1);
        if (cam_we)       mon_pop(0, 19'd0, cam_prop, cam_data);
        if (light_we)     mon_pop(1, {13'b0, light_idx}, light_prop, light_data);
        if (shape_we)     mon_pop(2, shape_idx, shape_prop, shape_data);
        if (render_start) mon_pop(3, 19'd0, 5'd0, 16'd0);
        if (frame_swap)   mon_pop(4, 19'd0, 5'd0, 16'd0);
    end

    function automatic logic writes_scene(input InstType t);
        return t inside {opCameraSet, opLightSet, opShapeInit, opShapeSet, opShapeData};
    endfunction

    // Reference model: what an accepted instruction must produce, and its effect on the counters.
    task automatic push_expect(input DecodedInst x, input bit both);
        case (x.iType)
            opCameraSet: q.push_back('{0, 19'd0, x.prop, x.data});
            opLightSet: begin
                q.push_back('{1, {13'b0, x.lIndex}, x.prop, x.data});
                if (int'(x.lIndex) + 1 > m_nl) m_nl = int'(x.lIndex) + 1;
            end
            opShapeInit: begin
                q.push_back('{2, x.sIndex, 5'd31, {11'b0, x.sType}});
                if (x.sType != stOff && int'(x.sIndex) + 1 > m_ns) m_ns = int'(x.sIndex) + 1;
            end
            opShapeSet: q.push_back('{2, x.sIndex, x.prop, x.data});
            opShapeData: begin
                q.push_back('{2, x.sIndex, x.prop, x.data});
                if (both) q.push_back('{2, x.sIndex, x.prop2, x.data2});
            end
            opRender: q.push_back('{3, 19'd0, 5'd0, 16'd0});
            opFrame:  q.push_back('{4, 19'd0, 5'd0, 16'd0});
            default:  if (m_err < 255) m_err++;
        endcase
    endtask

    task automatic check_counters();
        chk("num_lights", {25'b0, num_lights}, 32'(m_nl));
        chk("num_shapes", {12'b0, num_shapes}, 32'(m_ns));
        chk("err_count", {24'b0, err_count}, 32'(m_err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobes"}, {27'b0, cam_we, light_we, shape_we, render_start, frame_swap}, 32'd0);
        chk({tag, "_cam"}, {11'b0, cam_prop, cam_data}, 32'd0);
        chk({tag, "_light"}, {5'b0, light_idx, light_prop, light_data}, 32'd0);
        chk({tag, "_shape_idx"}, {13'b0, shape_idx}, 32'd0);
        chk({tag, "_shape_pd"}, {11'b0, shape_prop, shape_data}, 32'd0);
        chk({tag, "_counts"}, {5'b0, num_lights, num_shapes}, 32'd0);
        chk({tag, "_err"}, {24'b0, err_count}, 32'd0);
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge with it idle again.
    // dly < 0 picks a random acknowledge delay for render/frame.
    task automatic issue(input DecodedInst x, input int dly);
        bit accepted;
        int tries;
        int d;
        accepted = 0;
        tries = 0;
        inst = x;
        inst_valid = 1'b1;
        while (!accepted && tries < 30) begin
            #1;
            chk("inst_ready", {31'b0, inst_ready}, {31'b0, !(render_busy && writes_scene(x.iType))});
            if (inst_ready) begin
                accepted = 1;
                push_expect(x, 1);
            end
            @(negedge clk);
            if (!accepted) begin
                tries++;
                if ($urandom_range(0, 1) == 1) render_busy = 1'b0;
            end
        end
        inst_valid = 1'b0;
        inst = DecodedInst'({$urandom, $urandom, $urandom});
        if (!accepted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 30 cycles at %0t", $time);
            render_busy = 1'b0;
            return;
        end
        case (x.iType)
            opShapeData: begin
                #1;
                chk("ready_in_wr2", {31'b0, inst_ready}, 32'd0);
                @(negedge clk);
            end
            opRender, opFrame: begin
                d = (dly < 0) ? $urandom_range(0, 4) : dly;
                repeat (d) begin
                    #1;
                    chk("ready_in_wait", {31'b0, inst_ready}, 32'd0);
                    @(negedge clk);
                end
                if (x.iType == opRender) render_done = 1'b1;
                else                     frame_done  = 1'b1;
                #1;
                chk("ready_at_done", {31'b0, inst_ready}, 32'd0);
                @(negedge clk);
                render_done = 1'b0;
                frame_done  = 1'b0;
            end
            default: ;
        endcase
        check_counters();
    endtask

    function automatic DecodedInst rand_inst();
        DecodedInst x;
        x = DecodedInst'({$urandom, $urandom, $urandom});
        x.iType = InstType'($urandom_range(0, 7));
        x.sType = ShapeType'($urandom_range(0, 5));
        if ($urandom_range(0, 3) != 0) x.sIndex = 19'($urandom_range(0, 200));
        return x;
    endfunction

    function automatic DecodedInst mk(input InstType t);
        DecodedInst x;
        x = '0;
        x.iType = t;
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1);
    end

    initial begin
        DecodedInst x;
        rst_n = 1'b0;
        inst_valid = 1'b0;
        inst = '0;
        render_busy = 1'b0;
        render_done = 1'b0;
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        chk("reset_ready", {31'b0, inst_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Camera FOV write.
        x = mk(opCameraSet); x.prop = 5'd12; x.data = 16'h3C00;
        issue(x, -1);

        // Two-beat shape data.
        x = mk(opShapeData); x.sIndex = 19'd5; x.prop = 5'd1; x.data = 16'h4000;
        x.prop2 = 5'd2; x.data2 = 16'h4200;
        issue(x, -1);

        // Shape init grows the table only upward.
        x = mk(opShapeInit); x.sIndex = 19'd9; x.sType = stSphere;
        issue(x, -1);
        chk("num_shapes_after_9", {12'b0, num_shapes}, 32'd10);
        x.sIndex = 19'd3;
        issue(x, -1);
        chk("num_shapes_after_3", {12'b0, num_shapes}, 32'd10);

        // Render acknowledged 4 cycles later, then a light write held off by render_busy.
        issue(mk(opRender), 4);
        render_busy = 1'b1;
        x = mk(opLightSet); x.lIndex = 6'd63; x.prop = 5'd4; x.data = 16'hBEEF;
        issue(x, -1);
        chk("num_lights_max", {25'b0, num_lights}, 32'd64);

        // Frame acknowledged in the same cycle as the swap pulse.
        issue(mk(opFrame), 0);

        // Randomized traffic with stray acknowledgements while idle.
        for (int i = 0; i < 300; i++) begin
            render_busy = ($urandom_range(0, 9) < 3);
            issue(rand_inst(), -1);
            render_busy = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) render_done = 1'b1;
                else                           frame_done  = 1'b1;
                @(negedge clk);
                render_done = 1'b0;
                frame_done  = 1'b0;
                #1;
                chk("idle_after_stray_done", {31'b0, inst_ready}, 32'd1);
                @(negedge clk);
            end
        end

        // Saturating error counter.
        for (int i = 0; i < 300; i++) issue(mk(opUnsupported), -1);
        chk("err_saturated", {24'b0, err_count}, 32'd255);

        // Reset while the second shape write is pending: it must be dropped.
        x = mk(opShapeData); x.sIndex = 19'd7; x.prop = 5'd3; x.data = 16'h1111;
        x.prop2 = 5'd6; x.data2 = 16'h2222;
        inst = x;
        inst_valid = 1'b1;
        #1;
        chk("wr2_reset_ready", {31'b0, inst_ready}, 32'd1);
        push_expect(x, 0);
        @(negedge clk);
        inst_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_nl = 0; m_ns = 0; m_err = 0;
        check_zero("wr2_reset");
        @(negedge clk);
        check_zero("wr2_reset_after");

        // Reset while waiting for render_done: the later done pulse is ignored.
        inst = mk(opRender);
        inst_valid = 1'b1;
        #1;
        chk("rw_reset_ready", {31'b0, inst_ready}, 32'd1);
        push_expect(mk(opRender), 1);
        @(negedge clk);
        inst_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        render_done = 1'b1;
        @(negedge clk);
        render_done = 1'b0;
        #1;
        check_zero("rw_reset");
        chk("rw_reset_ready_after", {31'b0, inst_ready}, 32'd1);
        @(negedge clk);

        // Still operational after reset.
        x = mk(opLightSet); x.lIndex = 6'd2; x.prop = 5'd1; x.data = 16'h0042;
        issue(x, -1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
